// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-port round-robin packet arbiter feeding a shared uart_tx
module uart_tx_arbiter #(
  parameter logic [15:0] GAP_TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic       last0,
  input  logic       last1,
  output logic       ack0,
  output logic       ack1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       abort_err,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_active,
  input  logic       tx_done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;        // port that wins a simultaneous request
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_prev_q;
  logic [1:0]  gnt_d;
  logic [7:0]  tx_byte_d;
  logic        tx_dv_d, ack0_d, ack1_d, abort_d, busy_d;

  logic        uart_ready, done_rise, sel_port, req_sel, last_sel, timeout_hit;
  logic [7:0]  byte_sel;

  assign uart_ready  = !tx_active && !tx_done;
  assign done_rise   = tx_done && !done_prev_q;
  assign sel_port    = gnt[1];
  assign req_sel     = sel_port ? req1  : req0;
  assign byte_sel    = sel_port ? byte1 : byte0;
  assign last_sel    = sel_port ? last1 : last0;
  assign timeout_hit = (GAP_TIMEOUT != 16'd0) && (cnt_q == GAP_TIMEOUT - 16'd1);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt;
    tx_byte_d = tx_byte;
    tx_dv_d   = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    abort_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_d = 2'b00;
        if (req0 || req1) begin
          if (req0 && req1) gnt_d = rr_q ? 2'b10 : 2'b01;
          else              gnt_d = req1 ? 2'b10 : 2'b01;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (uart_ready && req_sel) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = byte_sel;
          ack0_d    = !sel_port;
          ack1_d    = sel_port;
          last_d    = last_sel;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          if (last_q) begin
            gnt_d   = 2'b00;
            rr_d    = !sel_port;
            state_d = S_IDLE;
          end else begin
            cnt_d   = 16'd0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (req_sel) begin
          state_d = S_SEND;
        end else if (timeout_hit) begin
          abort_d = 1'b1;
          gnt_d   = 2'b00;
          rr_d    = !sel_port;
          state_d = S_IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          // saturates only when the timeout is disabled
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= 16'd0;
      done_prev_q <= 1'b0;
      gnt         <= 2'b00;
      tx_byte     <= 8'h00;
      tx_dv       <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      abort_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      done_prev_q <= tx_done;
      gnt         <= gnt_d;
      tx_byte     <= tx_byte_d;
      tx_dv       <= tx_dv_d;
      ack0        <= ack0_d;
      ack1        <= ack1_d;
      abort_err   <= abort_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a behavioural uart_tx
module tb_uart_tx_arbiter;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
  logic [7:0] byte0 = 8'h00, byte1 = 8'h00;
  logic       ack0, ack1, busy, abort_err, tx_dv;
  logic [1:0] gnt;
  logic [7:0] tx_byte;
  logic       tx_active = 1'b0, tx_done = 1'b0, serial = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.GAP_TIMEOUT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .byte0(byte0), .byte1(byte1),
    .last0(last0), .last1(last1), .ack0(ack0), .ack1(ack1),
    .gnt(gnt), .busy(busy), .abort_err(abort_err),
    .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done)
  );

  // uart_tx model: no reset, 2-cycle tx_done tail
  logic [9:0] frame = 10'h3FF;
  int bit_idx = 0, clk_cnt = 0, done_cnt = 0, viol = 0, cyc = 0, frame_end_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_dv && (tx_active || tx_done)) viol <= viol + 1;
    if (tx_active) begin
      if (clk_cnt == CPB - 1) begin
        clk_cnt <= 0;
        if (bit_idx == 9) begin
          tx_active     <= 1'b0;
          tx_done       <= 1'b1;
          done_cnt      <= 0;
          serial        <= 1'b1;
          frame_end_cyc <= cyc + 1;
        end else begin
          bit_idx <= bit_idx + 1;
          serial  <= frame[bit_idx + 1];
        end
      end else begin
        clk_cnt <= clk_cnt + 1;
      end
    end else if (tx_done) begin
      if (done_cnt == 1) tx_done <= 1'b0;
      else               done_cnt <= done_cnt + 1;
    end else if (tx_dv) begin
      frame     <= {1'b1, tx_byte, 1'b0};
      tx_active <= 1'b1;
      bit_idx   <= 0;
      clk_cnt   <= 0;
      serial    <= 1'b0;
    end
  end

  // serial line decoder
  int         rx_cnt = 0;
  logic       rx_on = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (!rx_on) begin
      if (!serial) begin
        rx_on  <= 1'b1;
        rx_cnt <= 0;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0) rx_sh <= {serial, rx_sh[7:1]};
      if (rx_cnt == 35) rx_q.push_back(rx_sh);
      if (rx_cnt == 38) rx_on <= 1'b0;
    end
  end

  // requesters: present queue head, advance on ack
  typedef struct packed {logic [7:0] d; logic l;} item_t;
  item_t q0[$], q1[$];

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end
    if (ack0 && q0.size() > 0) void'(q0.pop_front());
    if (ack1 && q1.size() > 0) void'(q1.pop_front());
    req0 = (q0.size() > 0);
    req1 = (q1.size() > 0);
    if (req0) {byte0, last0} = {q0[0].d, q0[0].l};
    if (req1) {byte1, last1} = {q1[0].d, q1[0].l};
  end

  // monitor
  logic [9:0] txlog[$];
  logic [1:0] gnt_hist[$];
  logic [1:0] gnt_prev = 2'b00;
  logic       dv_prev = 1'b0, ab_prev = 1'b0, a0_prev = 1'b0, a1_prev = 1'b0, done_prev = 1'b0;
  int ack0_n = 0, ack1_n = 0, bad_ack = 0, wide = 0, dv_cyc = 0, done_rise_cyc = 0;

  always @(negedge clk) begin
    if (tx_dv) begin
      txlog.push_back({tx_byte, gnt});
      dv_cyc <= cyc;
    end
    if (ack0) ack0_n <= ack0_n + 1;
    if (ack1) ack1_n <= ack1_n + 1;
    if ((ack0 && gnt != 2'b01) || (ack1 && gnt != 2'b10)) bad_ack <= bad_ack + 1;
    if ((tx_dv && dv_prev) || (abort_err && ab_prev) || (ack0 && a0_prev) || (ack1 && a1_prev))
      wide <= wide + 1;
    if (gnt != gnt_prev) gnt_hist.push_back(gnt);
    if (tx_done && !done_prev) done_rise_cyc <= cyc;
    gnt_prev  <= gnt;
    dv_prev   <= tx_dv;
    ab_prev   <= abort_err;
    a0_prev   <= ack0;
    a1_prev   <= ack1;
    done_prev <= tx_done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_logs();
    @(posedge clk); #1;
    txlog.delete();
    gnt_hist.delete();
    rx_q.delete();
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n = 0;
    while ((busy || tx_active || tx_done || req0 || req1 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_quiet: still busy after %0d cycles, required idle", name, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_log(input int cnt, input int budget, input string name);
    int n = 0;
    while (txlog.size() < cnt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (txlog.size() < cnt) begin
      errors++;
      $display("FAIL %s_log: %0d tx_dv seen, required %0d", name, txlog.size(), cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 7;
    if (tx_dv !== 1'b0)      begin errors++; $display("FAIL reset_tx_dv: got %b want 0", tx_dv); end
    if (tx_byte !== 8'h00)   begin errors++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
    if (ack0 !== 1'b0)       begin errors++; $display("FAIL reset_ack0: got %b want 0", ack0); end
    if (ack1 !== 1'b0)       begin errors++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    if (gnt !== 2'b00)       begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (abort_err !== 1'b0)  begin errors++; $display("FAIL reset_abort: got %b want 0", abort_err); end
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    logic [9:0] e[$];
    logic [7:0] r[$];
    int a0;
    a0 = ack0_n;
    clear_logs();
    q0.push_back({8'hA5, 1'b0});
    q0.push_back({8'h3C, 1'b0});
    q0.push_back({8'h0F, 1'b1});
    @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt_lat: got %b want 01", gnt); end
    if (tx_dv !== 1'b0) begin errors++; $display("FAIL single_dv_early: got %b want 0", tx_dv); end
    @(negedge clk);
    checks += 3;
    if (tx_dv !== 1'b1) begin errors++; $display("FAIL single_dv_lat: got %b want 1", tx_dv); end
    if (ack0 !== 1'b1) begin errors++; $display("FAIL single_ack_lat: got %b want 1", ack0); end
    if (tx_byte !== 8'hA5) begin errors++; $display("FAIL single_byte0: got %h want a5", tx_byte); end
    wait_quiet(1000, "single");
    e = '{{8'hA5, 2'b01}, {8'h3C, 2'b01}, {8'h0F, 2'b01}};
    r = '{8'hA5, 8'h3C, 8'h0F};
    checks += 4;
    if (txlog.size() != 3) begin errors++; $display("FAIL single_count: got %0d want 3", txlog.size()); end
    if (rx_q.size() != 3) begin errors++; $display("FAIL single_rx_count: got %0d want 3", rx_q.size()); end
    if (ack0_n - a0 != 3) begin errors++; $display("FAIL single_acks: got %0d want 3", ack0_n - a0); end
    if (gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_end: got %b want 00", gnt); end
    for (int i = 0; i < 3 && i < txlog.size(); i++) begin
      checks++;
      if (txlog[i] !== e[i]) begin errors++; $display("FAIL single_tx[%0d]: got %h/%b want %h/%b", i, txlog[i][9:2], txlog[i][1:0], e[i][9:2], e[i][1:0]); end
    end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== r[i]) begin errors++; $display("FAIL single_rx[%0d]: got %h want %h", i, rx_q[i], r[i]); end
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] e[$];
    logic [1:0] h[$];
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_logs();
    q0.push_back({8'h11, 1'b0}); q0.push_back({8'h12, 1'b1});
    q1.push_back({8'h21, 1'b0}); q1.push_back({8'h22, 1'b1});
    wait_quiet(1000, "simul");
    e = '{{8'h11, 2'b01}, {8'h12, 2'b01}, {8'h21, 2'b10}, {8'h22, 2'b10}};
    h = '{2'b01, 2'b00, 2'b10, 2'b00};
    checks += 2;
    if (txlog.size() != 4) begin errors++; $display("FAIL simul_count: got %0d want 4", txlog.size()); end
    if (gnt_hist.size() != 4) begin errors++; $display("FAIL simul_hist_len: got %0d want 4", gnt_hist.size()); end
    for (int i = 0; i < 4 && i < txlog.size(); i++) begin
      checks++;
      if (txlog[i] !== e[i]) begin errors++; $display("FAIL simul_tx[%0d]: got %h/%b want %h/%b", i, txlog[i][9:2], txlog[i][1:0], e[i][9:2], e[i][1:0]); end
    end
    for (int i = 0; i < 4 && i < gnt_hist.size(); i++) begin
      checks++;
      if (gnt_hist[i] !== h[i]) begin errors++; $display("FAIL simul_gnt[%0d]: got %b want %b", i, gnt_hist[i], h[i]); end
    end
    clear_logs();
    q0.push_back({8'h13, 1'b1});
    q1.push_back({8'h23, 1'b1});
    wait_quiet(1000, "round2");
    checks += 3;
    if (txlog.size() != 2) begin errors++; $display("FAIL round2_count: got %0d want 2", txlog.size()); end
    if (txlog.size() > 0 && txlog[0] !== {8'h13, 2'b01}) begin errors++; $display("FAIL round2_first: got %h want 13 on port 0", txlog[0][9:2]); end
    if (txlog.size() > 1 && txlog[1] !== {8'h23, 2'b10}) begin errors++; $display("FAIL round2_second: got %h want 23 on port 1", txlog[1][9:2]); end
  endtask

  task automatic test_fairness();
    logic [9:0] e[$];
    clear_logs();
    q0.push_back({8'h31, 1'b0}); q0.push_back({8'h32, 1'b1});
    q0.push_back({8'h33, 1'b0}); q0.push_back({8'h34, 1'b1});
    q0.push_back({8'h35, 1'b0}); q0.push_back({8'h36, 1'b1});
    wait_log(1, 200, "fair");
    q1.push_back({8'h41, 1'b1});
    wait_quiet(2000, "fair");
    e = '{{8'h31, 2'b01}, {8'h32, 2'b01}, {8'h41, 2'b10}, {8'h33, 2'b01},
          {8'h34, 2'b01}, {8'h35, 2'b01}, {8'h36, 2'b01}};
    checks++;
    if (txlog.size() != 7) begin errors++; $display("FAIL fair_count: got %0d want 7", txlog.size()); end
    for (int i = 0; i < 7 && i < txlog.size(); i++) begin
      checks++;
      if (txlog[i] !== e[i]) begin errors++; $display("FAIL fair_tx[%0d]: got %h/%b want %h/%b", i, txlog[i][9:2], txlog[i][1:0], e[i][9:2], e[i][1:0]); end
    end
  endtask

  task automatic test_gap_timeout();
    int n = 0;
    clear_logs();
    q1.push_back({8'h51, 1'b0});
    wait_log(1, 200, "gap");
    q0.push_back({8'h61, 1'b1});
    while (abort_err !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks += 4;
    if (abort_err !== 1'b1) begin errors++; $display("FAIL gap_abort: no abort_err within %0d cycles", n); end
    if (cyc - done_rise_cyc != 9) begin errors++; $display("FAIL gap_timing: abort %0d edges after tx_done rise, want 9", cyc - done_rise_cyc); end
    if (gnt !== 2'b00) begin errors++; $display("FAIL gap_gnt: got %b want 00", gnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy: got %b want 0", busy); end
    @(negedge clk);
    checks += 2;
    if (abort_err !== 1'b0) begin errors++; $display("FAIL gap_abort_width: got %b want 0", abort_err); end
    if (gnt !== 2'b01) begin errors++; $display("FAIL gap_regrant: got %b want 01", gnt); end
    wait_quiet(1000, "gap");
    checks += 3;
    if (txlog.size() != 2) begin errors++; $display("FAIL gap_count: got %0d want 2", txlog.size()); end
    if (txlog.size() > 0 && txlog[0] !== {8'h51, 2'b10}) begin errors++; $display("FAIL gap_tx0: got %h/%b want 51/10", txlog[0][9:2], txlog[0][1:0]); end
    if (txlog.size() > 1 && txlog[1] !== {8'h61, 2'b01}) begin errors++; $display("FAIL gap_tx1: got %h/%b want 61/01", txlog[1][9:2], txlog[1][1:0]); end
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    q0.push_back({8'h71, 1'b0}); q0.push_back({8'h72, 1'b0});
    q0.push_back({8'h73, 1'b0}); q0.push_back({8'h74, 1'b1});
    wait_log(2, 300, "rstmid");
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 7;
    if (tx_dv !== 1'b0)     begin errors++; $display("FAIL rstmid_tx_dv: got %b want 0", tx_dv); end
    if (tx_byte !== 8'h00)  begin errors++; $display("FAIL rstmid_tx_byte: got %h want 00", tx_byte); end
    if (ack0 !== 1'b0)      begin errors++; $display("FAIL rstmid_ack0: got %b want 0", ack0); end
    if (ack1 !== 1'b0)      begin errors++; $display("FAIL rstmid_ack1: got %b want 0", ack1); end
    if (gnt !== 2'b00)      begin errors++; $display("FAIL rstmid_gnt: got %b want 00", gnt); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (abort_err !== 1'b0) begin errors++; $display("FAIL rstmid_abort: got %b want 0", abort_err); end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    q0.push_back({8'h81, 1'b1});
    wait_log(1, 300, "rstmid_next");
    checks += 2;
    if (txlog.size() > 0 && txlog[0] !== {8'h81, 2'b01}) begin errors++; $display("FAIL rstmid_next: got %h/%b want 81/01", txlog[0][9:2], txlog[0][1:0]); end
    if (dv_cyc < frame_end_cyc + 3) begin errors++; $display("FAIL rstmid_ready: tx_dv at %0d, frame ended %0d, want >= %0d", dv_cyc, frame_end_cyc, frame_end_cyc + 3); end
    wait_quiet(1000, "rstmid");
  endtask

  task automatic test_integrity();
    checks += 3;
    if (viol != 0)    begin errors++; $display("FAIL tx_dv_while_busy: got %0d want 0", viol); end
    if (bad_ack != 0) begin errors++; $display("FAIL ack_not_granted: got %0d want 0", bad_ack); end
    if (wide != 0)    begin errors++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_simultaneous();
    test_fairness();
    test_gap_timeout();
    test_reset_mid_frame();
    test_integrity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
